// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, JAL/JALR link value and EX/MEM register.
// Define MULDIV_EN to build the iterative RV32M multiply/divide unit, which stalls the front end while busy.
module ex_stage (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        Ctl_ALUSrc_in,
   input  logic        Ctl_MemtoReg_in,
   input  logic        Ctl_RegWrite_in,
   input  logic        Ctl_MemRead_in,
   input  logic        Ctl_MemWrite_in,
   input  logic [1:0]  Ctl_ALUOp_in,
   input  logic        jal_in,
   input  logic        jalr_in,
   input  logic [31:0] PC_in,
   input  logic [31:0] ReadData1_in,
   input  logic [31:0] ReadData2_in,
   input  logic [31:0] Immediate_in,
   input  logic [6:0]  funct7_in,
   input  logic [2:0]  funct3_in,
   input  logic [4:0]  Rd_in,
   input  logic [1:0]  ForwardA,
   input  logic [1:0]  ForwardB,
   input  logic [31:0] ExMem_fwd,
   input  logic [31:0] MemWb_fwd,
   output logic        Ctl_MemtoReg_out,
   output logic        Ctl_RegWrite_out,
   output logic        Ctl_MemRead_out,
   output logic        Ctl_MemWrite_out,
   output logic [31:0] ALUResult_out,
   output logic [31:0] StoreData_out,
   output logic [4:0]  Rd_out,
   output logic [2:0]  funct3_out,
   output logic        ex_stall
);

   logic [31:0]        op_a, op_b_raw, op_b, alu_res, ex_res, m_result;
   logic signed [31:0] op_a_s, op_b_s;
   logic               alt_op, m_done;
   logic               memtoreg_q, regwrite_q, memread_q, memwrite_q;
   logic [31:0]        result_q, store_q;
   logic [4:0]         rd_q;
   logic [2:0]         f3_q;

   always_comb begin
      case (ForwardA)
         2'b10:   op_a = ExMem_fwd;
         2'b01:   op_a = MemWb_fwd;
         default: op_a = ReadData1_in;
      endcase
      case (ForwardB)
         2'b10:   op_b_raw = ExMem_fwd;
         2'b01:   op_b_raw = MemWb_fwd;
         default: op_b_raw = ReadData2_in;
      endcase
   end

   assign op_b   = Ctl_ALUSrc_in ? Immediate_in : op_b_raw;
   assign op_a_s = op_a;
   assign op_b_s = op_b;
   // I-type only honours funct7[5] for SRAI; for ADDI it is an immediate bit
   assign alt_op = (Ctl_ALUOp_in == 2'b10) ? funct7_in[5]
                                           : ((funct3_in == 3'b101) && funct7_in[5]);

   always_comb begin
      alu_res = op_a + op_b;
      if (Ctl_ALUOp_in[1]) begin
         case (funct3_in)
            3'b000:  alu_res = alt_op ? (op_a - op_b) : (op_a + op_b);
            3'b001:  alu_res = op_a << op_b[4:0];
            3'b010:  alu_res = {31'd0, (op_a_s < op_b_s)};
            3'b011:  alu_res = {31'd0, (op_a < op_b)};
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  begin
               if (alt_op) alu_res = op_a_s >>> op_b[4:0];
               else        alu_res = op_a >> op_b[4:0];
            end
            3'b110:  alu_res = op_a | op_b;
            default: alu_res = op_a & op_b;
         endcase
      end
   end

`ifdef MULDIV_EN
   typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} m_state_e;

   m_state_e    state_q;
   logic [4:0]  count_q;
   logic [2:0]  mf3_q;
   logic [63:0] acc_q, acc_d, mcand_q, prod;
   logic [31:0] mplier_q, abs_a, abs_b, quo, rem;
   logic        neg_q, rneg_q, sign_a, sign_b, m_issue, div_ge;
   logic [32:0] div_sh;

   assign m_issue  = (state_q == M_IDLE) && (Ctl_ALUOp_in == 2'b10) && (funct7_in == 7'b0000001);
   assign ex_stall = m_issue || (state_q == M_BUSY);
   assign m_done   = (state_q == M_DONE);

   // Work on magnitudes; the sign is reapplied to the final result
   assign sign_a = op_a[31] && ((funct3_in == 3'b001) || (funct3_in == 3'b010) ||
                                (funct3_in == 3'b100) || (funct3_in == 3'b110));
   assign sign_b = op_b[31] && ((funct3_in == 3'b001) || (funct3_in == 3'b100) ||
                                (funct3_in == 3'b110));
   assign abs_a  = sign_a ? -op_a : op_a;
   assign abs_b  = sign_b ? -op_b : op_b;

   // acc_q holds {remainder, dividend/quotient} for divides, the running product for multiplies
   assign div_sh = {acc_q[63:32], acc_q[31]};
   assign div_ge = div_sh >= {1'b0, mcand_q[31:0]};

   always_comb begin
      acc_d = acc_q;
      if (mf3_q[2]) begin
         acc_d[63:32] = div_ge ? (div_sh[31:0] - mcand_q[31:0]) : div_sh[31:0];
         acc_d[31:0]  = {acc_q[30:0], div_ge};
      end else if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   assign prod = neg_q  ? -acc_q         : acc_q;
   assign quo  = neg_q  ? -acc_q[31:0]   : acc_q[31:0];
   assign rem  = rneg_q ? -acc_q[63:32]  : acc_q[63:32];

   always_comb begin
      case (mf3_q)
         3'b000:        m_result = prod[31:0];
         3'b100, 3'b101: m_result = quo;
         3'b110, 3'b111: m_result = rem;
         default:       m_result = prod[63:32];
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= M_IDLE;
         count_q <= '0;
      end else begin
         case (state_q)
            M_IDLE: if (m_issue) begin
               state_q <= M_BUSY;
               count_q <= '0;
            end
            M_BUSY: begin
               count_q <= count_q + 5'd1;
               if (count_q == 5'd31) state_q <= M_DONE;
            end
            M_DONE:  state_q <= M_IDLE;
            default: state_q <= M_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (m_issue) begin
         mf3_q <= funct3_in;
         if (funct3_in[2]) begin
            acc_q   <= {32'd0, abs_a};
            mcand_q <= {32'd0, abs_b};
            neg_q   <= (sign_a ^ sign_b) && (op_b != 32'd0);
            rneg_q  <= sign_a;
         end else begin
            acc_q    <= '0;
            mcand_q  <= {32'd0, abs_a};
            mplier_q <= abs_b;
            neg_q    <= sign_a ^ sign_b;
            rneg_q   <= 1'b0;
         end
      end else if (state_q == M_BUSY) begin
         acc_q <= acc_d;
         if (!mf3_q[2]) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
         end
      end
   end
`else
   logic unused_funct7;
   assign unused_funct7 = ^{funct7_in[6], funct7_in[4:0]};
   assign ex_stall      = 1'b0;
   assign m_done        = 1'b0;
   assign m_result      = '0;
`endif

   assign ex_res = m_done ? m_result : ((jal_in | jalr_in) ? (PC_in + 32'd4) : alu_res);

   // EX/MEM register: a stall turns the slot into a bubble by clearing its control bits
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         result_q   <= '0;
         store_q    <= '0;
         rd_q       <= '0;
         f3_q       <= '0;
      end else begin
         memtoreg_q <= Ctl_MemtoReg_in & ~ex_stall;
         regwrite_q <= Ctl_RegWrite_in & ~ex_stall;
         memread_q  <= Ctl_MemRead_in  & ~ex_stall;
         memwrite_q <= Ctl_MemWrite_in & ~ex_stall;
         result_q   <= ex_res;
         store_q    <= op_b_raw;
         rd_q       <= Rd_in;
         f3_q       <= funct3_in;
      end
   end

   assign Ctl_MemtoReg_out = memtoreg_q;
   assign Ctl_RegWrite_out = regwrite_q;
   assign Ctl_MemRead_out  = memread_q;
   assign Ctl_MemWrite_out = memwrite_q;
   assign ALUResult_out    = result_q;
   assign StoreData_out    = store_q;
   assign Rd_out           = rd_q;
   assign funct3_out       = f3_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed ALU/forwarding/jump cases, random ALU traffic against a
// reference model, and (when MULDIV_EN is defined) M-unit latency, results and reset.
module tb_ex_stage;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        Ctl_ALUSrc_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in;
   logic [1:0]  Ctl_ALUOp_in;
   logic        jal_in, jalr_in;
   logic [31:0] PC_in, ReadData1_in, ReadData2_in, Immediate_in;
   logic [6:0]  funct7_in;
   logic [2:0]  funct3_in;
   logic [4:0]  Rd_in;
   logic [1:0]  ForwardA, ForwardB;
   logic [31:0] ExMem_fwd, MemWb_fwd;
   logic        Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out;
   logic [31:0] ALUResult_out, StoreData_out;
   logic [4:0]  Rd_out;
   logic [2:0]  funct3_out;
   logic        ex_stall;
   logic [75:0] got;

   int vectors = 0;
   int miscompares = 0;

   ex_stage dut (
      .CLK(CLK), .RESET(RESET),
      .Ctl_ALUSrc_in(Ctl_ALUSrc_in), .Ctl_MemtoReg_in(Ctl_MemtoReg_in),
      .Ctl_RegWrite_in(Ctl_RegWrite_in), .Ctl_MemRead_in(Ctl_MemRead_in),
      .Ctl_MemWrite_in(Ctl_MemWrite_in), .Ctl_ALUOp_in(Ctl_ALUOp_in),
      .jal_in(jal_in), .jalr_in(jalr_in), .PC_in(PC_in),
      .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in), .Immediate_in(Immediate_in),
      .funct7_in(funct7_in), .funct3_in(funct3_in), .Rd_in(Rd_in),
      .ForwardA(ForwardA), .ForwardB(ForwardB), .ExMem_fwd(ExMem_fwd), .MemWb_fwd(MemWb_fwd),
      .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
      .Ctl_MemRead_out(Ctl_MemRead_out), .Ctl_MemWrite_out(Ctl_MemWrite_out),
      .ALUResult_out(ALUResult_out), .StoreData_out(StoreData_out),
      .Rd_out(Rd_out), .funct3_out(funct3_out), .ex_stall(ex_stall)
   );

   always #5 CLK = ~CLK;

   assign got = {Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out,
                 ALUResult_out, StoreData_out, Rd_out, funct3_out};

   typedef struct packed {
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } alu_vec_t;

   function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ext;
      int          ia, ib;
      ia = a;
      ib = b;
      if (op[1] == 1'b0) return a + b;
      case (f3)
         3'b000: return (op == 2'b10 && f7[5]) ? a - b : a + b;
         3'b001: return a << b[4:0];
         3'b010: return (ia < ib) ? 32'd1 : 32'd0;
         3'b011: return (a < b) ? 32'd1 : 32'd0;
         3'b100: return a ^ b;
         3'b101: begin
            ext = f7[5] ? {{32{a[31]}}, a} : {32'd0, a};
            ext = ext >> b[4:0];
            return ext[31:0];
         end
         3'b110: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [75:0] expect_bundle();
      logic [31:0] a, braw, b, r;
      a    = (ForwardA == 2'b10) ? ExMem_fwd : (ForwardA == 2'b01) ? MemWb_fwd : ReadData1_in;
      braw = (ForwardB == 2'b10) ? ExMem_fwd : (ForwardB == 2'b01) ? MemWb_fwd : ReadData2_in;
      b    = Ctl_ALUSrc_in ? Immediate_in : braw;
      r    = (jal_in || jalr_in) ? PC_in + 32'd4 : ref_alu(Ctl_ALUOp_in, funct3_in, funct7_in, a, b);
      return {Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, r, braw, Rd_in, funct3_in};
   endfunction

   task automatic set_nop();
      {Ctl_ALUSrc_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in} = 5'd0;
      Ctl_ALUOp_in = 2'b00;
      jal_in = 1'b0;
      jalr_in = 1'b0;
      PC_in = '0;
      ReadData1_in = '0;
      ReadData2_in = '0;
      Immediate_in = '0;
      funct7_in = '0;
      funct3_in = '0;
      Rd_in = '0;
      ForwardA = 2'b00;
      ForwardB = 2'b00;
      ExMem_fwd = '0;
      MemWb_fwd = '0;
   endtask

   task automatic rand_op();
      logic [31:0] r, r2;
      r  = $urandom;
      r2 = $urandom;
      {Ctl_ALUSrc_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in} = r[4:0];
      Ctl_ALUOp_in = r[6:5];
      funct3_in    = r[9:7];
      ForwardA     = r[11:10];
      ForwardB     = r[13:12];
      Rd_in        = r[18:14];
      jal_in       = (r[23:19] == 5'd0);
      jalr_in      = (r[28:24] == 5'd0);
      if (Ctl_ALUOp_in == 2'b10) begin
         case (r[30:29])
            2'd1:    funct7_in = 7'h20;
`ifdef MULDIV_EN
            2'd2:    funct7_in = 7'h20;
`else
            2'd2:    funct7_in = 7'h01;
`endif
            default: funct7_in = 7'h00;
         endcase
      end else begin
         funct7_in = r2[6:0];
      end
      PC_in        = $urandom;
      ReadData1_in = $urandom;
      ReadData2_in = r2[31] ? {27'd0, r2[12:8]} : $urandom;
      Immediate_in = $urandom;
      ExMem_fwd    = $urandom;
      MemWb_fwd    = $urandom;
   endtask

   task automatic test_reset();
      logic [75:0] exp;
      set_nop();
      RESET = 1'b1;
      @(posedge CLK); #1;
      vectors++;
      if ({got, ex_stall} !== 77'd0)
         begin miscompares++; $display("FAIL reset_initial: got %h required 0", {got, ex_stall}); end
      RESET = 1'b0;
      {Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in} = 4'hF;
      ReadData1_in = 32'h1234;
      ReadData2_in = 32'h1;
      Rd_in = 5'd31;
      funct3_in = 3'b111;
      exp = expect_bundle();
      @(posedge CLK); #1;
      vectors++;
      if (got !== exp)
         begin miscompares++; $display("FAIL reset_preload: got %h required %h", got, exp); end
      RESET = 1'b1;
      #1;
      vectors++;
      if ({got, ex_stall} !== 77'd0)
         begin miscompares++; $display("FAIL reset_async: got %h required 0", {got, ex_stall}); end
      #1 RESET = 1'b0;
      set_nop();
   endtask

   task automatic test_alu();
      alu_vec_t tv[$];
      tv.push_back('{2'b00, 3'b000, 7'h00, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFFE});
      tv.push_back('{2'b10, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'hF8000000});
      tv.push_back('{2'b10, 3'b011, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd1});
      tv.push_back('{2'b10, 3'b010, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd0});
      tv.push_back('{2'b10, 3'b000, 7'h20, 32'd3, 32'd5, 32'hFFFFFFFE});
      tv.push_back('{2'b11, 3'b000, 7'h20, 32'd10, 32'd3, 32'd13});
      tv.push_back('{2'b11, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'hF8000000});
      tv.push_back('{2'b10, 3'b101, 7'h00, 32'h80000000, 32'd4, 32'h08000000});
      tv.push_back('{2'b01, 3'b000, 7'h20, 32'd8, 32'd1, 32'd9});
      tv.push_back('{2'b10, 3'b001, 7'h00, 32'd1, 32'd33, 32'd2});
`ifndef MULDIV_EN
      tv.push_back('{2'b10, 3'b000, 7'h01, 32'd9, 32'd2, 32'd11});
`endif
      for (int i = 0; i < tv.size(); i++) begin
         set_nop();
         Ctl_RegWrite_in = 1'b1;
         Ctl_ALUOp_in = tv[i].op;
         funct3_in = tv[i].f3;
         funct7_in = tv[i].f7;
         ReadData1_in = tv[i].a;
         ReadData2_in = tv[i].b;
         @(posedge CLK); #1;
         vectors++;
         if (ALUResult_out !== tv[i].e)
            begin miscompares++; $display("FAIL alu_%0d: got %h required %h", i, ALUResult_out, tv[i].e); end
      end
   endtask

   task automatic test_forwarding();
      set_nop();
      Ctl_RegWrite_in = 1'b1;
      ForwardA = 2'b10; ExMem_fwd = 32'h10;
      ForwardB = 2'b01; MemWb_fwd = 32'h3;
      ReadData1_in = 32'hDEAD0000; ReadData2_in = 32'hBEEF0000;
      @(posedge CLK); #1;
      vectors++;
      if (ALUResult_out !== 32'h13)
         begin miscompares++; $display("FAIL fwd_add: got %h required 00000013", ALUResult_out); end
      ForwardA = 2'b00; ReadData1_in = 32'h100;
      ForwardB = 2'b10; ExMem_fwd = 32'h55;
      Ctl_ALUSrc_in = 1'b1; Immediate_in = 32'd4;
      @(posedge CLK); #1;
      vectors++;
      if ({ALUResult_out, StoreData_out} !== {32'h104, 32'h55})
         begin miscompares++; $display("FAIL fwd_imm: got %h/%h required 00000104/00000055", ALUResult_out, StoreData_out); end
      ForwardA = 2'b11; ForwardB = 2'b11; Ctl_ALUSrc_in = 1'b0;
      ReadData1_in = 32'h7; ReadData2_in = 32'h9;
      @(posedge CLK); #1;
      vectors++;
      if ({ALUResult_out, StoreData_out} !== {32'h10, 32'h9})
         begin miscompares++; $display("FAIL fwd_11: got %h/%h required 00000010/00000009", ALUResult_out, StoreData_out); end
   endtask

   task automatic test_jal();
      set_nop();
      jal_in = 1'b1; Ctl_RegWrite_in = 1'b1; PC_in = 32'h100;
      ReadData1_in = 32'h5555; ReadData2_in = 32'h7;
      @(posedge CLK); #1;
      vectors++;
      if ({ALUResult_out, Ctl_RegWrite_out} !== {32'h104, 1'b1})
         begin miscompares++; $display("FAIL jal: got %h rw %b required 00000104 rw 1", ALUResult_out, Ctl_RegWrite_out); end
      jal_in = 1'b0; jalr_in = 1'b1; PC_in = 32'hFFFFFFFC;
      Ctl_ALUOp_in = 2'b10; funct7_in = 7'h20;
      @(posedge CLK); #1;
      vectors++;
      if (ALUResult_out !== 32'h0)
         begin miscompares++; $display("FAIL jalr_wrap: got %h required 00000000", ALUResult_out); end
   endtask

   task automatic test_random();
      logic [75:0] exp;
      logic        stall_seen;
      for (int i = 0; i < 200; i++) begin
         rand_op();
         exp = expect_bundle();
         #1 stall_seen = ex_stall;
         @(posedge CLK); #1;
         vectors++;
         if ({got, stall_seen} !== {exp, 1'b0})
            begin miscompares++; $display("FAIL random_%0d: got %h stall %b required %h stall 0", i, got, stall_seen, exp); end
      end
   endtask

   task automatic test_back_to_back();
      set_nop();
      Ctl_RegWrite_in = 1'b1;
      ReadData1_in = 32'd100; ReadData2_in = 32'd23;
      @(posedge CLK); #1;
      vectors++;
      if (ALUResult_out !== 32'd123)
         begin miscompares++; $display("FAIL b2b_1: got %h required 0000007b", ALUResult_out); end
      ForwardA = 2'b10; ExMem_fwd = 32'd123; Ctl_ALUSrc_in = 1'b1; Immediate_in = 32'd7;
      @(posedge CLK); #1;
      vectors++;
      if (ALUResult_out !== 32'd130)
         begin miscompares++; $display("FAIL b2b_2: got %h required 00000082", ALUResult_out); end
      ExMem_fwd = 32'd130; MemWb_fwd = 32'd123; ForwardB = 2'b01; Ctl_ALUSrc_in = 1'b0;
      Ctl_ALUOp_in = 2'b10; funct7_in = 7'h20;
      @(posedge CLK); #1;
      vectors++;
      if (ALUResult_out !== 32'd7)
         begin miscompares++; $display("FAIL b2b_3: got %h required 00000007", ALUResult_out); end
      set_nop();
   endtask

`ifdef MULDIV_EN
   function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      int          ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = a;
      ib = b;
      case (f3)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            return ia / ib;
         end
         3'b101: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
         3'b110: begin
            if (b == 32'd0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            return ia % ib;
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int stalls,
                          output logic bubble_ok, output logic rw);
      set_nop();
      Ctl_ALUOp_in = 2'b10; funct7_in = 7'h01; funct3_in = f3;
      Ctl_RegWrite_in = 1'b1; Rd_in = 5'd9;
      ForwardA = 2'b10; ExMem_fwd = a; ReadData2_in = b;
      #1;
      stalls = 0;
      bubble_ok = 1'b1;
      while (ex_stall === 1'b1 && stalls < 40) begin
         stalls++;
         @(posedge CLK); #1;
         ExMem_fwd = $urandom;
         if (Ctl_RegWrite_out !== 1'b0) bubble_ok = 1'b0;
      end
      @(posedge CLK); #1;
      res = ALUResult_out;
      rw  = Ctl_RegWrite_out;
      set_nop();
   endtask

   task automatic test_muldiv();
      logic [31:0] res, a, b, exp, r;
      int          stalls;
      logic        bub, rw;
      run_mop(3'b000, 32'd7, 32'hFFFFFFFD, res, stalls, bub, rw);
      vectors++;
      if (res !== 32'hFFFFFFEB)
         begin miscompares++; $display("FAIL mul_result: got %h required ffffffeb", res); end
      vectors++;
      if (stalls != 33)
         begin miscompares++; $display("FAIL mul_stall_cycles: got %0d required 33", stalls); end
      vectors++;
      if ({bub, rw} !== 2'b11)
         begin miscompares++; $display("FAIL mul_ctl: got bubble_ok %b rw %b required 1 1", bub, rw); end
      run_mop(3'b100, 32'd7, 32'd0, res, stalls, bub, rw);
      vectors++;
      if (res !== 32'hFFFFFFFF)
         begin miscompares++; $display("FAIL div_by_zero: got %h required ffffffff", res); end
      run_mop(3'b110, 32'h80000000, 32'hFFFFFFFF, res, stalls, bub, rw);
      vectors++;
      if (res !== 32'd0)
         begin miscompares++; $display("FAIL rem_overflow: got %h required 00000000", res); end
      run_mop(3'b100, 32'h80000000, 32'hFFFFFFFF, res, stalls, bub, rw);
      vectors++;
      if (res !== 32'h80000000)
         begin miscompares++; $display("FAIL div_overflow: got %h required 80000000", res); end
      run_mop(3'b111, 32'd5, 32'd0, res, stalls, bub, rw);
      vectors++;
      if (res !== 32'd5)
         begin miscompares++; $display("FAIL remu_by_zero: got %h required 00000005", res); end
      for (int i = 0; i < 16; i++) begin
         r = $urandom;
         a = $urandom;
         b = (r[7:4] == 4'd0) ? 32'd0 : (r[8] ? {28'd0, r[12:9]} : $urandom);
         exp = ref_m(r[2:0], a, b);
         run_mop(r[2:0], a, b, res, stalls, bub, rw);
         vectors++;
         if ({res, stalls[5:0], bub, rw} !== {exp, 6'd33, 2'b11})
            begin miscompares++; $display("FAIL m_random_%0d f3 %0d a %h b %h: got %h stalls %0d required %h stalls 33", i, r[2:0], a, b, res, stalls); end
      end
   endtask

   task automatic test_m_back_to_back();
      logic [31:0] res1, res2;
      int          s1, s2;
      logic        bub1, bub2, rw1, rw2;
      run_mop(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, res1, s1, bub1, rw1);
      run_mop(3'b101, 32'd100, 32'd7, res2, s2, bub2, rw2);
      vectors++;
      if ({res1, res2, s1[5:0], s2[5:0]} !== {32'hFFFFFFFE, 32'd14, 6'd33, 6'd33})
         begin miscompares++; $display("FAIL m_back_to_back: got %h %h stalls %0d %0d required fffffffe 0000000e stalls 33 33", res1, res2, s1, s2); end
   endtask

   task automatic test_reset_busy();
      set_nop();
      Ctl_ALUOp_in = 2'b10; funct7_in = 7'h01; funct3_in = 3'b000;
      Ctl_RegWrite_in = 1'b1; ReadData1_in = 32'd3; ReadData2_in = 32'd4;
      @(posedge CLK);
      repeat (10) @(posedge CLK);
      #1 RESET = 1'b1;
      #1;
      vectors++;
      if ({got, ex_stall} !== 77'd0)
         begin miscompares++; $display("FAIL reset_busy: got %h required 0", {got, ex_stall}); end
      RESET = 1'b0;
      set_nop();
      Ctl_RegWrite_in = 1'b1; ReadData1_in = 32'd2; ReadData2_in = 32'd3;
      #1;
      vectors++;
      if (ex_stall !== 1'b0)
         begin miscompares++; $display("FAIL reset_busy_stall: got %b required 0", ex_stall); end
      @(posedge CLK); #1;
      vectors++;
      if ({ALUResult_out, Ctl_RegWrite_out} !== {32'd5, 1'b1})
         begin miscompares++; $display("FAIL reset_busy_add: got %h rw %b required 00000005 rw 1", ALUResult_out, Ctl_RegWrite_out); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      set_nop();
      test_reset();
      test_alu();
      test_forwarding();
      test_jal();
      test_random();
      test_back_to_back();
`ifdef MULDIV_EN
      test_muldiv();
      test_m_back_to_back();
      test_reset_busy();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline, directly downstream of the decode stage and its ID/EX register. Selects forwarded operands, runs the ALU, computes the link value for JAL/JALR and drives the EX/MEM pipeline register. Optionally contains an iterative multiply/divide unit (RV32M) that stalls the front end while it runs.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- Ctl_ALUSrc_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in  in  1 each  ID/EX control bits
- Ctl_ALUOp_in  in  2  {ALUOpcode1, ALUOpcode0} from ID/EX
- jal_in, jalr_in  in  1 each  jump flags from ID/EX
- PC_in, ReadData1_in, ReadData2_in, Immediate_in  in  32 each  ID/EX data
- funct7_in  in  7;  funct3_in  in  3;  Rd_in  in  5
- ForwardA, ForwardB  in  2 each  00 = ID/EX register value, 10 = ExMem_fwd, 01 = MemWb_fwd, 11 = ID/EX register value
- ExMem_fwd, MemWb_fwd  in  32 each  forwarding sources
- Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out  out  1 each  EX/MEM control
- ALUResult_out, StoreData_out  out  32 each  EX/MEM data (StoreData = forwarded operand B before the ALUSrc mux)
- Rd_out  out  5;  funct3_out  out  3  (load/store width)
- ex_stall  out  1  combinational; hazard unit holds PC, IF/ID and ID/EX while high

## Operation
- opA = forward mux A. opB_raw = forward mux B. opB = Ctl_ALUSrc_in ? Immediate_in : opB_raw.
- ALUOp 00: add. 01: add (branches already resolved in decode; RegWrite is 0). 10: R-type by funct3, where funct7[5] selects SUB/SRA. 11: I-type by funct3, where funct7[5] is honoured only for funct3 101 (SRAI).
- Ops: ADD, SUB, SLL, SLT (signed), SLTU, XOR, SRL, SRA, OR, AND. Shift amount is opB[4:0]. All arithmetic wraps mod 2^32.
- jal_in | jalr_in: ALUResult = PC_in + 4, overriding the ALU.
- EX/MEM register, every non-stalled cycle: latches the control bits, result, StoreData, Rd_in and funct3_in.
- EX/MEM register while ex_stall = 1: control bits are forced to 0 (bubble). Data fields are don't-care.
- M-unit FSM (MULDIV_EN only). States IDLE, BUSY, DONE.
  - IDLE: if Ctl_ALUOp_in = 10 and funct7_in = 0000001, capture opA, opB and funct3, set count = 0, go to BUSY, ex_stall = 1.
  - BUSY: one shift-add or restoring-divide step per cycle, ex_stall = 1. After step 31, go to DONE.
  - DONE: ex_stall = 0, the M result is latched into EX/MEM with the captured control bits, then go to IDLE.
- M results follow the RISC-V spec for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - 0x80000000 / -1: quotient = 0x80000000, remainder = 0.

## Timing
- Non-M ops: single cycle. Result is visible on the EX/MEM outputs at the clock edge after the ID/EX edge.
- M ops: ex_stall is high for 33 cycles (issue cycle plus 32 BUSY cycles). The result is latched at the end of the 34th cycle.
- Operands are captured in the issue cycle. Forward-source changes during BUSY are ignored.
- Upstream must hold the ID/EX contents stable while ex_stall = 1. The block does not re-evaluate the instruction in DONE, apart from its control bits.
- RESET (asynchronous, at any time, including mid-BUSY): FSM goes to IDLE, count = 0, ex_stall = 0, every EX/MEM output = 0. The in-flight M op is discarded.
- Back-to-back M ops: DONE always returns to IDLE, so the next op issues one cycle later.

## Configuration
- MULDIV_EN defined: M-unit and FSM are compiled in.
- MULDIV_EN undefined: no FSM, ex_stall is tied to 0, and funct7 = 0000001 decodes as the base op selected by funct3 (funct7[5] = 0).

## Test plan
- Reset: assert RESET mid-stream -> all outputs 0 and ex_stall 0 immediately, without waiting for a clock edge.
- ALU: ADD 5 + (-7) -> 0xFFFFFFFE. SRA 0x80000000 >> 4 -> 0xF8000000. SLTU 1 < 0xFFFFFFFF -> 1. SLT 1 < -1 -> 0.
- Forwarding: ForwardA = 10 with ExMem_fwd = 0x10, ForwardB = 01 with MemWb_fwd = 0x3 under ADD -> 0x13. ALUSrc = 1 with imm 4 and ForwardB = 10 -> StoreData = ExMem_fwd and result = opA + 4.
- JAL with PC_in = 0x100 -> ALUResult 0x104, RegWrite 1.
- MULDIV_EN: MUL 7 * -3 -> 0xFFFFFFEB after exactly 33 stall cycles, with EX/MEM control 0 during those cycles. DIV 7 / 0 -> 0xFFFFFFFF. REM 0x80000000 % -1 -> 0.
- MULDIV_EN: RESET during BUSY at count 10 -> IDLE, and a following ADD completes in a single cycle.
